// File: rtl/pipe_stage_regs_pkg.sv
// Shared core constants for the fetch/decode/execute pipeline register bank.
//   CORE_XLEN     : default datapath width
//   CORE_RESET_PC : default fetch PC after reset
//   NOP_INSTR     : canonical RV32 NOP (addi x0, x0, 0) used for IF/ID bubbles
package pipe_stage_regs_pkg;

  localparam int unsigned CORE_XLEN     = 32;
  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

endpackage : pipe_stage_regs_pkg

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic W-bit pipeline register.
//   clk, rst : clock and asynchronous active-high reset (loads RST_VAL)
//   en       : load d when high, hold otherwise
//   clr      : load CLR_VAL; takes priority over en
//   d, q     : data in / registered data out
module pipe_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule : pipe_reg

// File: rtl/pipe_stage_regs.sv
// Fetch/decode/execute pipeline register bank for the 5-stage RV32 core.
// Holds PCF, the IF/ID and ID/EX registers with per-stage valid bits, and
// two performance counters (decode stall cycles, discarded valid slots).
//   Hazard controls : StallF, StallD, FlushD, FlushE
//   Fetch inputs    : PCNextF, InstrF
//   Decode inputs   : CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD
//   Fetch/decode out: PCF, InstrD, PCD, PCPlus4D, ValidD
//   Execute out     : CtrlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE,
//                     PCPlus4E, ValidE
//   Counters        : cnt_clr (sync clear), stall_cnt, flush_cnt
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned    XLEN     = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC),
  parameter int unsigned    CTRL_W   = 16,
  parameter int unsigned    CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [31:0]       InstrF,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic              ValidE,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned IFID_W = INSTR_W + 2 * XLEN + 1;
  localparam int unsigned IDEX_W = CTRL_W + 3 * REG_ADDR_W + 5 * XLEN + 1;

  // A decode bubble is a NOP with zeroed PCs, identical to the reset image.
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

  logic [IFID_W-1:0] ifid_d, ifid_q;
  logic [IDEX_W-1:0] idex_d, idex_q;

  // Fetch PC register
  pipe_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pcf (
    .clk (clk),
    .rst (rst),
    .en  (~StallF),
    .clr (1'b0),
    .d   (PCNextF),
    .q   (PCF)
  );

  // IF/ID register: FlushD beats StallD beats load
  assign ifid_d = {InstrF, PCF, PCF + XLEN'(4), 1'b1};

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_BUBBLE),
    .CLR_VAL (IFID_BUBBLE)
  ) u_ifid (
    .clk (clk),
    .rst (rst),
    .en  (~StallD),
    .clr (FlushD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;

  // ID/EX register: no stall; a flush zeroes everything so RdE=0 never matches
  assign idex_d = {CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ValidD};

  pipe_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_idex (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (FlushE),
    .d   (idex_d),
    .q   (idex_q)
  );

  assign {CtrlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ValidE} = idex_q;

  // Performance counter increments for this edge
  logic       stall_inc_c;
  logic [1:0] flush_inc_c;

  always_comb begin
    stall_inc_c = StallD & ~FlushD & ValidD;
    flush_inc_c = {1'b0, FlushD & ValidD} + {1'b0, FlushE & ValidE};
  end

  // Counters wrap naturally; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(stall_inc_c);
      flush_cnt <= flush_cnt + CNT_W'(flush_inc_c);
    end
  end

endmodule : pipe_stage_regs

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs (CNT_W reduced to 8 so wrap is reachable).
module tb_pipe_stage_regs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              StallF, StallD, FlushD, FlushE;
  logic [XLEN-1:0]   PCNextF;
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   PCF, PCD, PCPlus4D;
  logic [31:0]       InstrD;
  logic              ValidD;
  logic [CTRL_W-1:0] CtrlD, CtrlE;
  logic [4:0]        Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic [XLEN-1:0]   RD1D, RD2D, ImmExtD;
  logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic              ValidE;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_regs #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .PCNextF   (PCNextF),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .CtrlD     (CtrlD),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdD       (RdD),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
    .ImmExtD   (ImmExtD),
    .CtrlE     (CtrlE),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RD1E      (RD1E),
    .RD2E      (RD2E),
    .ImmExtE   (ImmExtE),
    .PCE       (PCE),
    .PCPlus4E  (PCPlus4E),
    .ValidE    (ValidE),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {StallF, StallD, FlushD, FlushE, cnt_clr} = '0;
    PCNextF = 32'h4;
    InstrF  = 32'h0050_0093;
    CtrlD   = 16'hA5A5;
    Rs1D    = 5'd2;
    Rs2D    = 5'd3;
    RdD     = 5'd1;
    RD1D    = 32'h1111_1111;
    RD2D    = 32'h2222_2222;
    ImmExtD = 32'h0000_0005;
    #2;

    // Reset state
    chk("rst_pcf",    64'(PCF),       64'h0);
    chk("rst_instrd", 64'(InstrD),    64'(NOP));
    chk("rst_pcd",    64'(PCD),       64'h0);
    chk("rst_pcp4d",  64'(PCPlus4D),  64'h0);
    chk("rst_validd", 64'(ValidD),    64'h0);
    chk("rst_valide", 64'(ValidE),    64'h0);
    chk("rst_rde",    64'(RdE),       64'h0);
    chk("rst_ctrle",  64'(CtrlE),     64'h0);
    chk("rst_stall",  64'(stall_cnt), 64'h0);
    chk("rst_flush",  64'(flush_cnt), 64'h0);

    step();
    rst = 1'b0;

    // 1: first fetch from RESET_PC
    step();
    chk("t1_pcf",    64'(PCF),      64'h4);
    chk("t1_instrd", 64'(InstrD),   64'h0050_0093);
    chk("t1_pcd",    64'(PCD),      64'h0);
    chk("t1_pcp4d",  64'(PCPlus4D), 64'h4);
    chk("t1_validd", 64'(ValidD),   64'h1);
    chk("t1_valide", 64'(ValidE),   64'h0);
    PCNextF = 32'h8;
    step();
    chk("t1b_pcf",   64'(PCF),      64'h8);
    chk("t1b_pcd",   64'(PCD),      64'h4);
    chk("t1b_valide",64'(ValidE),   64'h1);
    chk("t1b_pce",   64'(PCE),      64'h0);
    chk("t1b_pcp4e", 64'(PCPlus4E), 64'h4);
    chk("t1b_rde",   64'(RdE),      64'h1);
    chk("t1b_rs1e",  64'(Rs1E),     64'h2);
    chk("t1b_rs2e",  64'(Rs2E),     64'h3);
    chk("t1b_ctrle", 64'(CtrlE),    64'hA5A5);
    chk("t1b_rd1e",  64'(RD1E),     64'h1111_1111);
    chk("t1b_rd2e",  64'(RD2E),     64'h2222_2222);
    chk("t1b_imme",  64'(ImmExtE),  64'h5);
    PCNextF = 32'hC;
    InstrF  = 32'h00A0_0113;
    step();
    chk("t1c_pcf",   64'(PCF),    64'hC);
    chk("t1c_instr", 64'(InstrD), 64'h00A0_0113);
    chk("t1c_pcd",   64'(PCD),    64'h8);

    // 2: load-use stall with E bubble
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    PCNextF = 32'h10;
    InstrF  = 32'hDEAD_BEEF;
    step();
    chk("t2_pcf",    64'(PCF),       64'hC);
    chk("t2_instrd", 64'(InstrD),    64'h00A0_0113);
    chk("t2_pcd",    64'(PCD),       64'h8);
    chk("t2_validd", 64'(ValidD),    64'h1);
    chk("t2_valide", 64'(ValidE),    64'h0);
    chk("t2_rde",    64'(RdE),       64'h0);
    chk("t2_ctrle",  64'(CtrlE),     64'h0);
    chk("t2_pce",    64'(PCE),       64'h0);
    chk("t2_stall",  64'(stall_cnt), 64'h1);
    chk("t2_flush",  64'(flush_cnt), 64'h1);
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    InstrF = 32'h0020_81B3;
    step();
    chk("t2b_pcf",   64'(PCF),       64'h10);
    chk("t2b_instr", 64'(InstrD),    64'h0020_81B3);
    chk("t2b_pcp4d", 64'(PCPlus4D),  64'h10);
    chk("t2b_pce",   64'(PCE),       64'h8);
    chk("t2b_valide",64'(ValidE),    64'h1);
    chk("t2b_stall", 64'(stall_cnt), 64'h1);

    // 3: taken branch flushes both stages
    FlushD = 1'b1; FlushE = 1'b1;
    PCNextF = 32'h100;
    step();
    chk("t3_pcf",    64'(PCF),       64'h100);
    chk("t3_instrd", 64'(InstrD),    64'(NOP));
    chk("t3_pcd",    64'(PCD),       64'h0);
    chk("t3_pcp4d",  64'(PCPlus4D),  64'h0);
    chk("t3_validd", 64'(ValidD),    64'h0);
    chk("t3_valide", 64'(ValidE),    64'h0);
    chk("t3_flush",  64'(flush_cnt), 64'h3);
    FlushD = 1'b0; FlushE = 1'b0;
    InstrF  = 32'h0050_0093;
    PCNextF = 32'h104;
    step();
    chk("t3b_pcd",   64'(PCD),    64'h100);
    chk("t3b_validd",64'(ValidD), 64'h1);
    chk("t3b_valide",64'(ValidE), 64'h0);

    // 4: FlushD beats StallD, no stall counted
    FlushD = 1'b1; StallD = 1'b1;
    PCNextF = 32'h108;
    step();
    chk("t4_instrd", 64'(InstrD),    64'(NOP));
    chk("t4_validd", 64'(ValidD),    64'h0);
    chk("t4_valide", 64'(ValidE),    64'h1);
    chk("t4_stall",  64'(stall_cnt), 64'h1);
    chk("t4_flush",  64'(flush_cnt), 64'h4);
    FlushD = 1'b0;
    step();
    chk("t4b_stall_invalid", 64'(stall_cnt), 64'h1);
    chk("t4b_flush",         64'(flush_cnt), 64'h4);

    // 5: clear, count up to all-ones, wrap, then clear beats increment
    StallD  = 1'b0;
    cnt_clr = 1'b1;
    step();
    chk("t5_clr_stall", 64'(stall_cnt), 64'h0);
    chk("t5_clr_flush", 64'(flush_cnt), 64'h0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      FlushE = 1'b0;
      step();
      FlushE = 1'b1;
      step();
    end
    chk("t5_full",  64'(flush_cnt), 64'hFF);
    FlushE = 1'b0;
    step();
    FlushE = 1'b1;
    step();
    chk("t5_wrap",  64'(flush_cnt), 64'h0);
    FlushE = 1'b0;
    step();
    chk("t5_pre_clr", 64'(ValidE), 64'h1);
    FlushE = 1'b1; StallD = 1'b1; cnt_clr = 1'b1;
    step();
    chk("t5_clrpri_flush", 64'(flush_cnt), 64'h0);
    chk("t5_clrpri_stall", 64'(stall_cnt), 64'h0);
    FlushE = 1'b0; cnt_clr = 1'b0;
    step();
    chk("t5_resume_stall", 64'(stall_cnt), 64'h1);
    StallD = 1'b0;
    step();
    chk("t6_pre_pcf", 64'(PCF), 64'h108);
    chk("t6_pre_rde", 64'(RdE), 64'h1);

    // 6: asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pcf",    64'(PCF),       64'h0);
    chk("t6_instrd", 64'(InstrD),    64'(NOP));
    chk("t6_validd", 64'(ValidD),    64'h0);
    chk("t6_valide", 64'(ValidE),    64'h0);
    chk("t6_rde",    64'(RdE),       64'h0);
    chk("t6_stall",  64'(stall_cnt), 64'h0);
    chk("t6_flush",  64'(flush_cnt), 64'h0);
    step();
    rst = 1'b0;
    PCNextF = 32'h4;
    step();
    chk("t6_rel_pcf", 64'(PCF), 64'h4);
    chk("t6_rel_pcd", 64'(PCD), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_regs

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
Fetch/decode/execute pipeline register bank for the 5-stage RV32 core. It consumes the stall and flush controls from the hazard unit.
- Holds PCF, the IF/ID register and the ID/EX register.
- Carries per-stage valid bits.
- Keeps two performance counters (stall cycles, flushed slots) for the CSR file.

Parameters:
XLEN, 32, datapath width.
RESET_PC, 32'h0000_0000, PCF value after reset.
CTRL_W, 16, width of the opaque decoded-control bundle carried D->E.
CNT_W, 64, width of each performance counter.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous, active-high reset.
StallF  input  1  hold PCF.
StallD  input  1  hold IF/ID register.
FlushD  input  1  clear IF/ID register (bubble).
FlushE  input  1  clear ID/EX register (bubble).
PCNextF  input  XLEN  next PC from the PC mux.
InstrF  input  32  instruction-memory read data.
PCF  output  XLEN  current fetch PC.
InstrD  output  32  decode-stage instruction.
PCD  output  XLEN  decode-stage PC.
PCPlus4D  output  XLEN  PCD+4, computed internally from PCF+4 at capture.
ValidD  output  1  decode slot holds a real instruction.
CtrlD  input  CTRL_W  decoded control bundle.
Rs1D, Rs2D, RdD  input  5 each  register specifiers.
RD1D, RD2D, ImmExtD  input  XLEN each  operand and immediate values.
CtrlE  output  CTRL_W  registered control bundle.
Rs1E, Rs2E, RdE  output  5 each  registered specifiers.
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  XLEN each  registered datapath values.
ValidE  output  1  execute slot holds a real instruction.
cnt_clr  input  1  synchronous clear of both counters.
stall_cnt  output  CNT_W  cycles in which StallD held a valid decode slot.
flush_cnt  output  CNT_W  valid instructions discarded by FlushD/FlushE.

Behaviour:
- Reset (async, rst=1):
  - PCF=RESET_PC.
  - InstrD=32'h0000_0013 (NOP).
  - PCD, PCPlus4D = 0.
  - ValidD=0, ValidE=0.
  - All E-stage outputs 0, including RdE=0 and CtrlE=0.
  - Both counters 0.
  - Release is effective at the next clk rising edge; first fetch uses RESET_PC.
- PCF: on each rising edge, PCF<=PCNextF unless StallF=1 (hold).
- IF/ID priority on each edge: FlushD > StallD > load.
  - FlushD: InstrD<=NOP, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - StallD (no FlushD): hold all IF/ID fields.
  - Load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4 (mod 2^XLEN), ValidD<=1.
- ID/EX has no stall input:
  - FlushE: every E output <=0, ValidE<=0. A cleared RdE=0 guarantees no false load-use or forwarding match downstream.
  - Otherwise: capture all D inputs plus PCD/PCPlus4D; ValidE<=ValidD.
- Single-cycle latency per stage; no combinational path from any input to any output.
- Simultaneous FlushD and FlushE: both stages bubble in the same edge.
- Simultaneous StallD and FlushE (load-use): D holds, E bubbles. This is the normal load-use pattern.
- stall_cnt: +1 on each edge with StallD=1 & FlushD=0 & ValidD=1.
- flush_cnt: per edge, adds (FlushD&ValidD)+(FlushE&ValidE), i.e. 0..2.
- Counter rules:
  - Both counters wrap modulo 2^CNT_W.
  - cnt_clr has priority over increment; counter becomes 0 that edge.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk; in-flight instructions are dropped without counting.

Decomposition:
- Shared core package: NOP_INSTR=32'h0000_0013, RESET_PC default, XLEN.
- One natural sub-module: pipe_reg (generic W-bit register with en, clr, async rst, clr>en priority). Instantiate it for PCF, IF/ID and ID/EX, then add the counter logic at top level.

Test Plan:
1. Reset then release, InstrF=32'h00500093, PCNextF=PCF+4:
   - PCF sequence is 0, 4, 8.
   - One edge after release: InstrD=32'h00500093, PCD=0, PCPlus4D=4, ValidD=1.
2. Load-use: assert StallF=StallD=FlushE=1 for one cycle with ValidD=1:
   - PCF and InstrD are unchanged.
   - ValidE=0, RdE=0, CtrlE=0.
   - stall_cnt +1, flush_cnt +1 if ValidE was 1.
3. Branch taken: FlushD=FlushE=1 with ValidD=ValidE=1, PCNextF=32'h100:
   - InstrD=NOP, ValidD=0, ValidE=0.
   - flush_cnt +2; next edge PCF=32'h100.
4. FlushD and StallD together: FlushD wins, InstrD=NOP, stall_cnt unchanged.
5. Preload flush_cnt to all-ones and flush one valid slot -> flush_cnt=0. Then cnt_clr together with an increment -> 0.
6. Pulse rst mid-stream, between clock edges: outputs return to reset values before the next edge; ValidD=ValidE=0.
